// File: rtl/pe_array_seq_ctrl_if.sv
// rtl/pe_array_seq_ctrl_if.sv - handshake and bus bundle between the PE sequencer and its neighbours
//
// Groups the job request, tile-buffer read ports, PE cluster drive/return
// signals and the result-tile port.
//   master : the sequencer (drives reads, cluster controls, result tile)
//   slave  : the surroundings (job source, tile buffers, cluster, consumer)
interface pe_array_seq_ctrl_if #(
   parameter int DW     = 16,
   parameter int ACC_W  = 36,
   parameter int KMAX_W = 8
);
   logic                  start;
   logic [KMAX_W-1:0]     k_len;
   logic                  busy;
   logic                  act_rd_en;
   logic [KMAX_W-1:0]     act_rd_addr;
   logic [8*DW-1:0]       act_rd_data;
   logic                  wgt_rd_en;
   logic [KMAX_W-1:0]     wgt_rd_addr;
   logic [8*DW-1:0]       wgt_rd_data;
   logic                  arr_en;
   logic [8*DW-1:0]       arr_activations;
   logic [8*DW-1:0]       arr_weights;
   logic [7:0]            arr_done;
   logic [63:0]           arr_output_dones;
   logic [64*ACC_W-1:0]   arr_results;
   logic                  res_valid;
   logic                  res_ready;
   logic [64*ACC_W-1:0]   res_data;
   logic                  res_err;
   logic [15:0]           cycle_count;

   modport master (
      input  start, k_len, act_rd_data, wgt_rd_data, arr_output_dones,
             arr_results, res_ready,
      output busy, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr, arr_en,
             arr_activations, arr_weights, arr_done, res_valid, res_data,
             res_err, cycle_count
   );

   modport slave (
      output start, k_len, act_rd_data, wgt_rd_data, arr_output_dones,
             arr_results, res_ready,
      input  busy, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr, arr_en,
             arr_activations, arr_weights, arr_done, res_valid, res_data,
             res_err, cycle_count
   );
endinterface

// File: rtl/pe_array_seq_ctrl.sv
// rtl/pe_array_seq_ctrl.sv - job sequencer for the 8x8 systolic PE cluster
//
// One job computes one 8x8 output tile: clear the cluster, stream k_len
// K-slices from the tile buffers through the diagonal skew, wait for every
// PE to report done (or time out), then hold the captured tile on a
// valid/ready port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pe_array_seq_ctrl_if.master (job request, buffer reads,
//                cluster drive/return, result tile, cycle_count)
// Optional macro SEQ_CYCLE_CNT_EN: enables the 16-bit busy-cycle counter on
// cycle_count; without it cycle_count is tied to 0.
module pe_array_seq_ctrl #(
   parameter int DW            = 16,
   parameter int ACC_W         = 36,
   parameter int KMAX_W        = 8,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pe_array_seq_ctrl_if.master   bus
);
   localparam int DC_W = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUTPUT} state_t;

   state_t               state;
   logic [KMAX_W-1:0]    k_lat;
   logic                 clr_cnt;
   logic [DC_W-1:0]      drain_cnt;
   logic                 rd_en;
   logic [KMAX_W-1:0]    rd_addr;
   logic                 busy_q;
   logic                 arr_en_q;
   logic                 res_valid_q;
   logic                 res_err_q;
   logic [64*ACC_W-1:0]  res_q;

   // read-data qualifiers: read data is valid the cycle after the strobe
   logic                 rd_vld;
   logic                 rd_last;
   logic [7:0]           done_sh;
   wire  [8*DW-1:0]      act_sk;
   wire  [8*DW-1:0]      wgt_sk;

   wire start_ok = (state == S_IDLE) && bus.start && (bus.k_len != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         k_lat       <= '0;
         clr_cnt     <= 1'b0;
         drain_cnt   <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         busy_q      <= 1'b0;
         arr_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  k_lat   <= bus.k_len;
                  busy_q  <= 1'b1;
                  clr_cnt <= 1'b0;
                  state   <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               // two cycles with arr_en low so the cluster's registered clear lands
               clr_cnt <= 1'b1;
               if (clr_cnt) begin
                  arr_en_q <= 1'b1;
                  rd_en    <= 1'b1;
                  rd_addr  <= '0;
                  state    <= S_FEED;
               end
            end
            S_FEED: begin
               if (rd_addr == k_lat - 1'b1) begin
                  rd_en     <= 1'b0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               if (&bus.arr_output_dones) begin
                  res_q       <= bus.arr_results;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state       <= S_OUTPUT;
               end else if (drain_cnt == DC_W'(DRAIN_TIMEOUT - 1)) begin
                  // DRAIN_TIMEOUT cycles spent here: hand out whatever the cluster holds
                  res_q       <= bus.arr_results;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state       <= S_OUTPUT;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  arr_en_q    <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld  <= 1'b0;
         rd_last <= 1'b0;
         done_sh <= '0;
      end else begin
         rd_vld  <= rd_en;
         rd_last <= rd_en && (rd_addr == k_lat - 1'b1);
         // done token travels with stage 0, so bit i lines up with lane i's skew
         done_sh <= {done_sh[6:0], rd_vld & rd_last};
      end
   end

   // lane i: stage 0 captures the returned read data (zero when no read is
   // in flight), then i more registers give the diagonal skew
   for (genvar i = 0; i < 8; i++) begin : g_lane
      logic [DW-1:0] a_p [0:i];
      logic [DW-1:0] w_p [0:i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int d = 0; d <= i; d++) begin
               a_p[d] <= '0;
               w_p[d] <= '0;
            end
         end else begin
            a_p[0] <= rd_vld ? bus.act_rd_data[i*DW +: DW] : '0;
            w_p[0] <= rd_vld ? bus.wgt_rd_data[i*DW +: DW] : '0;
            for (int d = 1; d <= i; d++) begin
               a_p[d] <= a_p[d-1];
               w_p[d] <= w_p[d-1];
            end
         end
      end

      assign act_sk[i*DW +: DW] = a_p[i];
      assign wgt_sk[i*DW +: DW] = w_p[i];
   end

`ifdef SEQ_CYCLE_CNT_EN
   logic [15:0] cyc_cnt;

   // counts busy cycles up to the result tile, then freezes until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= '0;
      end else if (start_ok) begin
         cyc_cnt <= '0;
      end else if (busy_q && !res_valid_q && cyc_cnt != 16'hFFFF) begin
         cyc_cnt <= cyc_cnt + 16'd1;
      end
   end

   assign bus.cycle_count = cyc_cnt;
`else
   assign bus.cycle_count = '0;
`endif

   assign bus.busy            = busy_q;
   assign bus.act_rd_en       = rd_en;
   assign bus.act_rd_addr     = rd_addr;
   assign bus.wgt_rd_en       = rd_en;
   assign bus.wgt_rd_addr     = rd_addr;
   assign bus.arr_en          = arr_en_q;
   assign bus.arr_activations = act_sk;
   assign bus.arr_weights     = wgt_sk;
   assign bus.arr_done        = done_sh;
   assign bus.res_valid       = res_valid_q;
   assign bus.res_err         = res_err_q;
   assign bus.res_data        = res_q;
endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// tb/tb_pe_array_seq_ctrl.sv - self-checking bench for pe_array_seq_ctrl
module tb_pe_array_seq_ctrl;
   localparam int DW     = 16;
   localparam int ACC_W  = 36;
   localparam int KMAX_W = 8;
   localparam int TO     = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pe_array_seq_ctrl_if #(.DW(DW), .ACC_W(ACC_W), .KMAX_W(KMAX_W)) bus ();

   pe_array_seq_ctrl #(.DW(DW), .ACC_W(ACC_W), .KMAX_W(KMAX_W), .DRAIN_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- tile buffers ----------------
   logic [DW-1:0] amem [0:255][0:7];
   logic [DW-1:0] bmem [0:255][0:7];

   always @(posedge clk) begin
      if (bus.act_rd_en)
         for (int i = 0; i < 8; i++) bus.act_rd_data[i*DW +: DW] <= amem[bus.act_rd_addr][i];
      if (bus.wgt_rd_en)
         for (int j = 0; j < 8; j++) bus.wgt_rd_data[j*DW +: DW] <= bmem[bus.wgt_rd_addr][j];
   end

   task automatic fill(input int mode);
      for (int k = 0; k < 256; k++)
         for (int i = 0; i < 8; i++) begin
            case (mode)
               0: begin amem[k][i] = 16'd1;            bmem[k][i] = 16'd1;            end
               1: begin amem[k][i] = DW'(i + 1);       bmem[k][i] = DW'(i + 1);       end
               2: begin amem[k][i] = DW'(k + 1);       bmem[k][i] = DW'(k + 1);       end
               default: begin amem[k][i] = 16'hFFFF;   bmem[k][i] = 16'hFFFF;         end
            endcase
         end
   endtask

   // ---------------- behavioural systolic cluster ----------------
   logic [DW-1:0]    a_r [8][8];
   logic [DW-1:0]    w_r [8][8];
   logic             d_r [8][8];
   logic             f_r [8][8];
   logic [ACC_W-1:0] acc [8][8];
   logic [DW-1:0]    a_in [8][8];
   logic [DW-1:0]    w_in [8][8];
   logic             d_in [8][8];
   logic [63:0]      force_mask = '0;
   logic [63:0]      done_flat;
   logic [64*ACC_W-1:0] res_flat;

   always_comb begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
               a_in[r][c] = bus.arr_activations[r*DW +: DW];
               d_in[r][c] = bus.arr_done[r];
            end else begin
               a_in[r][c] = a_r[r][c-1];
               d_in[r][c] = d_r[r][c-1];
            end
            if (r == 0) w_in[r][c] = bus.arr_weights[c*DW +: DW];
            else        w_in[r][c] = w_r[r-1][c];
            done_flat[8*r+c] = f_r[r][c];
            res_flat[(8*r+c)*ACC_W +: ACC_W] = acc[r][c];
         end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            if (!rst_n || !bus.arr_en) begin
               a_r[r][c] <= '0; w_r[r][c] <= '0; d_r[r][c] <= 1'b0;
               f_r[r][c] <= 1'b0; acc[r][c] <= '0;
            end else begin
               a_r[r][c] <= a_in[r][c];
               w_r[r][c] <= w_in[r][c];
               d_r[r][c] <= d_in[r][c];
               f_r[r][c] <= f_r[r][c] | d_in[r][c];
               acc[r][c] <= acc[r][c] + ACC_W'(a_in[r][c]) * ACC_W'(w_in[r][c]);
            end
         end
   end

   assign bus.arr_output_dones = done_flat & ~force_mask;
   assign bus.arr_results      = res_flat;

   // ---------------- scoreboard and monitors ----------------
   typedef struct {
      logic [64*ACC_W-1:0] tile;
      logic                err;
   } sb_t;
   sb_t sb_q [$];
   sb_t sb_e;

   function automatic logic [64*ACC_W-1:0] exp_tile(input int k);
      logic [64*ACC_W-1:0] t;
      logic [ACC_W-1:0]    s;
      t = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            s = '0;
            for (int kk = 0; kk < k; kk++) s = s + ACC_W'(amem[kk][r]) * ACC_W'(bmem[kk][c]);
            t[(8*r+c)*ACC_W +: ACC_W] = s;
         end
      return t;
   endfunction

   function automatic int first_diff(input logic [64*ACC_W-1:0] a, input logic [64*ACC_W-1:0] b);
      for (int p = 0; p < 64; p++)
         if (a[p*ACC_W +: ACC_W] !== b[p*ACC_W +: ACC_W]) return p;
      return -1;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc++;

   int busy_meas = 0, last_rd_cyc = 0, rv_cyc = 0, rv_pulses = 0;
   int d0_cnt = 0, d3_cnt = 0, d0_cyc = 0, d3_cyc = 0, didx;
   logic rv_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.start) busy_meas = 0;
      else if (bus.busy && !bus.res_valid) busy_meas++;
      if (bus.act_rd_en) last_rd_cyc = cyc;
      if (bus.res_valid && !rv_prev) begin rv_pulses++; rv_cyc = cyc; end
      rv_prev = bus.res_valid;
      if (bus.arr_done[0]) begin d0_cnt++; d0_cyc = cyc; end
      if (bus.arr_done[3]) begin d3_cnt++; d3_cyc = cyc; end
      if (rst_n && bus.res_valid && bus.res_ready) begin
         if (sb_q.size() == 0) begin
            chk(1'b0, "unexpected_tile", 1, 0);
         end else begin
            sb_e = sb_q.pop_front();
            didx = first_diff(bus.res_data, sb_e.tile);
            if (didx < 0) chk(1'b1, "tile", 0, 0);
            else chk(1'b0, $sformatf("tile_pe%0d", didx), 64'(bus.res_data[didx*ACC_W +: ACC_W]),
                     64'(sb_e.tile[didx*ACC_W +: ACC_W]));
            chk(bus.res_err == sb_e.err, "tile_err", 64'(bus.res_err), 64'(sb_e.err));
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic start_job(input int k, input logic err);
      sb_t e;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.k_len = KMAX_W'(k);
      e.tile = exp_tile(k);
      e.err  = err;
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_res(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (bus.res_valid) begin ok = 1'b1; break; end
      end
      if (!ok) chk(1'b0, "res_valid_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int lim);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!bus.busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk(1'b0, "idle_timeout", 1, 0);
   endtask

   function automatic bit outs_zero();
      return !bus.busy && !bus.act_rd_en && !bus.wgt_rd_en && !bus.arr_en &&
             bus.arr_done == '0 && bus.arr_activations == '0 && bus.arr_weights == '0 &&
             !bus.res_valid && !bus.res_err && bus.cycle_count == '0;
   endfunction

   // ---------------- test ----------------
   typedef struct {
      int               k;
      int               mode;
      logic [ACC_W-1:0] corner;
      logic [ACC_W-1:0] pe00;
   } vec_t;
   vec_t vecs [6];

   initial begin
      bit ok;
      int rv0, d00, d30, bad;
      logic [63:0] exp_cc;

      vecs[0] = '{8,   0, 36'd8,          36'd8};
      vecs[1] = '{4,   1, 36'd256,        36'd4};
      vecs[2] = '{5,   2, 36'd55,         36'd55};
      vecs[3] = '{2,   3, 36'd8589672450, 36'd8589672450};
      vecs[4] = '{255, 0, 36'd255,        36'd255};
      vecs[5] = '{1,   1, 36'd64,         36'd1};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.res_ready = 1'b1;
      fill(0);
      repeat (3) @(negedge clk);
      chk(outs_zero(), "reset_outputs", 0, 0);
      rst_n = 1'b1;

      // k_len == 0 must be ignored
      @(posedge clk); #1; bus.start = 1'b1; bus.k_len = '0;
      @(posedge clk); #1; bus.start = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy || bus.act_rd_en || bus.arr_en) bad++;
      end
      chk(bad == 0, "klen0_ignored", bad, 0);

      for (int v = 0; v < 6; v++) begin
         fill(vecs[v].mode);
         rv0 = rv_pulses; d00 = d0_cnt; d30 = d3_cnt;
         start_job(vecs[v].k, 1'b0);
         wait_res(vecs[v].k + 300, ok);
         if (ok) begin
            chk(bus.res_data[63*ACC_W +: ACC_W] == vecs[v].corner, $sformatf("v%0d_pe77", v),
                64'(bus.res_data[63*ACC_W +: ACC_W]), 64'(vecs[v].corner));
            chk(bus.res_data[0 +: ACC_W] == vecs[v].pe00, $sformatf("v%0d_pe00", v),
                64'(bus.res_data[0 +: ACC_W]), 64'(vecs[v].pe00));
            chk(!bus.res_err, $sformatf("v%0d_err", v), 64'(bus.res_err), 0);
`ifdef SEQ_CYCLE_CNT_EN
            exp_cc = 64'(busy_meas);
`else
            exp_cc = 64'd0;
`endif
            chk(64'(bus.cycle_count) == exp_cc, $sformatf("v%0d_cycle_count", v), 64'(bus.cycle_count), exp_cc);
         end
         wait_idle(50);
         repeat (4) @(negedge clk);
         chk(rv_pulses - rv0 == 1, $sformatf("v%0d_valid_pulses", v), rv_pulses - rv0, 1);
         chk(d0_cnt - d00 == 1 && d3_cnt - d30 == 1 && d3_cyc - d0_cyc == 3,
             $sformatf("v%0d_done_skew", v), d3_cyc - d0_cyc, 3);
      end

      // back-pressure: tile held, starts ignored
      fill(1);
      bus.res_ready = 1'b0;
      start_job(3, 1'b0);
      wait_res(200, ok);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         bus.start = (c == 5 || c == 10);
         bus.k_len = 8'd5;
         @(negedge clk);
         if (!bus.res_valid || !bus.busy) bad++;
         if (sb_q.size() == 0 || bus.res_data !== sb_q[0].tile) bad++;
      end
      chk(bad == 0, "hold_stable", bad, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk(!bus.busy && !bus.res_valid && !bus.arr_en, "release_idle",
          64'({bus.busy, bus.res_valid, bus.arr_en}), 0);
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.busy || bus.res_valid) bad++;
      end
      chk(bad == 0, "no_queued_start", bad, 0);

      // drain timeout with one PE done flag stuck low
      fill(0);
      force_mask = 64'h20;
      start_job(4, 1'b1);
      wait_res(300, ok);
      if (ok) chk(bus.res_err, "timeout_err", 64'(bus.res_err), 1);
      @(negedge clk);
      chk(rv_cyc - last_rd_cyc == TO + 1, "timeout_latency", rv_cyc - last_rd_cyc, TO + 1);
      force_mask = '0;
      wait_idle(50);

      // reset during FEED (read n=3), then a clean k_len=2 job
      fill(0);
      start_job(8, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.act_rd_en && bus.act_rd_addr == 8'd3) begin ok = 1'b1; break; end
      end
      chk(ok, "reach_feed3", 64'(ok), 1);
      rst_n = 1'b0;
      #1;
      chk(outs_zero(), "midjob_reset_outputs", 0, 0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      fill(2);
      start_job(2, 1'b0);
      wait_res(200, ok);
      if (ok) chk(bus.res_data[63*ACC_W +: ACC_W] == 36'd5, "post_reset_pe77",
                  64'(bus.res_data[63*ACC_W +: ACC_W]), 5);
      wait_idle(50);
      repeat (3) @(negedge clk);
      chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
